pulse_ctrl_multi: RTL and testbench

- Parametrised successor of the single-engine stepper pulse generator.
- Drives N_CH stepper drivers (PU/MF/DR per channel) from one shared step engine:
  - runs a sequential homing pass over all channels against limit switches;
  - then accepts commands (channel, step count, direction, programmable half-period) over a valid/ready handshake.
- Adds abort, homing timeout, limit-hit fault and per-channel signed position tracking.
- Sits between the command sequencer and the motor driver pins.

---
 rtl/pulse_pkg.sv | 24 ++
 rtl/step_gen.sv | 58 +++++
 rtl/pulse_ctrl_multi.sv | 234 +++++++++++++++++++++++
 tb/tb_pulse_ctrl_multi.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// pulse_pkg: shared definitions for the multi-channel stepper pulse controller.
//   state_t    - controller state encoding
//   FLT_*      - fault codes reported on the fault output
//   clamp_half - maps a half-period of 0 to 1 so the step engine never stalls
package pulse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEEK = 3'd1,
        ST_BACK = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_HOME_TO = 2'b01;
    localparam logic [1:0] FLT_LIMIT   = 2'b10;
    localparam logic [1:0] FLT_ABORT   = 2'b11;

    function automatic logic [31:0] clamp_half(input logic [31:0] half);
        return (half == 32'd0) ? 32'd1 : half;
    endfunction

endpackage

// File: rtl/step_gen.sv
// step_gen: shared step engine, half-period counter plus PU phase flop.
//   sysclk, rst - clock, asynchronous active-high reset
//   start       - (re)arm: PU held high this edge, first falling edge one cycle later
//   kill        - stop immediately, PU forced high (has priority over start)
//   half        - half-period in cycles, must be >= 1
//   pu          - step pulse, idle high, low phase first
//   step_done   - high in the last low-phase cycle; the step completes on the next edge
//   phase_end   - high in the last high-phase cycle of a completed step (step boundary)
module step_gen #(
    parameter int DIV_W = 23
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             start,
    input  logic             kill,
    input  logic [DIV_W-1:0] half,
    output logic             pu,
    output logic             step_done,
    output logic             phase_end
);

    logic             act;
    logic             fresh;   // armed but no step begun yet: entry is not a boundary
    logic [DIV_W-1:0] cnt;
    logic             zero;

    assign zero      = (cnt == '0);
    assign step_done = act & ~pu & zero;
    assign phase_end = act & pu & zero & ~fresh;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            act   <= 1'b0;
            fresh <= 1'b0;
            pu    <= 1'b1;
            cnt   <= '0;
        end else if (kill) begin
            act   <= 1'b0;
            fresh <= 1'b0;
            pu    <= 1'b1;
            cnt   <= '0;
        end else if (start) begin
            act   <= 1'b1;
            fresh <= 1'b1;
            pu    <= 1'b1;
            cnt   <= '0;
        end else if (act) begin
            if (!zero) begin
                cnt <= cnt - DIV_W'(1);
            end else begin
                pu  <= ~pu;
                cnt <= half - DIV_W'(1);
                if (pu) fresh <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pulse_ctrl_multi.sv
// pulse_ctrl_multi: N_CH-channel stepper pulse controller with one shared step engine.
// Homes all channels in turn against their limit switches, then executes
// (channel, steps, dir, half) commands over a valid/ready handshake.
//   sysclk, RST          - clock, asynchronous active-high reset
//   INIT                 - re-home request (IDLE only, beats cmd_valid)
//   cmd_*                - command handshake; out-of-range channel or 0 steps just pulses done
//   abort                - stop motion now
//   Stop                 - asynchronous limit switches
//   Busy, done, fault    - status; fault sticky until the next accepted INIT
//   homed                - per-channel homing-complete flags
//   PU, MF, DR           - driver pins; only the active channel's PU/MF move
//   pos_sel, pos_rd      - combinational position readback
module pulse_ctrl_multi
    import pulse_pkg::*;
#(
    parameter int   N_CH      = 6,
    parameter int   CH_W      = 3,
    parameter int   CNT_W     = 10,
    parameter int   DIV_W     = 23,
    parameter int   POS_W     = 16,
    parameter int   HOME_HALF = 3000000,
    parameter int   HOME_MAX  = 1023,
    parameter logic HOME_DIR  = 1'b0
) (
    input  logic              sysclk,
    input  logic              RST,
    input  logic              INIT,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [CNT_W-1:0]  cmd_steps,
    input  logic              cmd_dir,
    input  logic [DIV_W-1:0]  cmd_half,
    input  logic              abort,
    input  logic [N_CH-1:0]   Stop,
    output logic              Busy,
    output logic [N_CH-1:0]   homed,
    output logic              done,
    output logic [1:0]        fault,
    output logic [N_CH-1:0]   PU,
    output logic [N_CH-1:0]   MF,
    output logic [N_CH-1:0]   DR,
    input  logic [CH_W-1:0]   pos_sel,
    output logic [POS_W-1:0]  pos_rd
);

    typedef struct packed {
        logic [CNT_W-1:0] steps;
        logic [DIV_W-1:0] half;
    } cmd_t;

    state_t                     state, nxt;
    cmd_t                       cmd;
    logic [CH_W-1:0]            ch;
    logic [CNT_W-1:0]           stp_cnt;
    logic                       stop_seen;
    logic [N_CH-1:0]            stop_m, stop_s, stop_d;
    logic [N_CH-1:0]            chsel;
    logic                       act, stop_ch, stop_rise;
    logic                       accept, bad_cmd;
    logic                       gen_start, gen_kill, pu, step_done, phase_end;
    logic [DIV_W-1:0]           half_cur;
    logic                       dr_we, dr_val;
    logic [CH_W-1:0]            dr_tgt;
    logic                       pos_step, home_set;
    logic [N_CH-1:0][POS_W-1:0] pos;

    // Limit switches: 2-flop synchroniser plus one delay stage for edge detect.
    always_ff @(posedge sysclk or posedge RST) begin
        if (RST) begin
            stop_m <= '0;
            stop_s <= '0;
            stop_d <= '0;
        end else begin
            stop_m <= Stop;
            stop_s <= stop_m;
            stop_d <= stop_s;
        end
    end

    assign stop_ch   = |(stop_s & chsel);
    assign stop_rise = |(stop_s & ~stop_d & chsel);
    assign act       = state inside {ST_SEEK, ST_BACK, ST_RUN};
    assign Busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign cmd_ready = (state == ST_IDLE) & (&homed) & (fault == FLT_NONE);
    assign accept    = cmd_valid & cmd_ready;
    assign bad_cmd   = (cmd_steps == '0) | (int'(cmd_ch) >= N_CH);
    assign half_cur  = (state == ST_RUN) ? cmd.half : DIV_W'(HOME_HALF);

    // Priority inside each state: abort, then Stop, then step completion.
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: begin
                if (INIT)        nxt = ST_SEEK;
                else if (accept) nxt = bad_cmd ? ST_DONE : ST_RUN;
            end
            ST_SEEK: begin
                if (abort)                                    nxt = ST_IDLE;
                else if (phase_end && (stop_seen || stop_rise)) nxt = ST_BACK;
                else if (stp_cnt == CNT_W'(HOME_MAX) && !stop_seen && !stop_rise)
                                                              nxt = ST_IDLE;
            end
            ST_BACK: begin
                if (abort)                       nxt = ST_IDLE;
                else if (phase_end && !stop_ch)  nxt = (ch == CH_W'(N_CH-1)) ? ST_IDLE : ST_SEEK;
                else if (stp_cnt == CNT_W'(HOME_MAX)) nxt = ST_IDLE;
            end
            ST_RUN: begin
                if (abort || stop_ch || stp_cnt == cmd.steps) nxt = ST_DONE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Any change into a moving state restarts the engine so every phase begins
    // with one idle-high cycle; leaving the moving states kills it.
    assign gen_start = (nxt != state) && (nxt inside {ST_SEEK, ST_BACK, ST_RUN});
    assign gen_kill  = act && !(nxt inside {ST_SEEK, ST_BACK, ST_RUN});

    // A step aborted or cut by the limit switch in RUN does not count.
    assign pos_step = step_done & act & ~abort & ~((state == ST_RUN) & stop_ch);
    assign home_set = (state == ST_BACK) & ~abort & phase_end & ~stop_ch;

    always_comb begin
        dr_we  = 1'b0;
        dr_val = HOME_DIR;
        dr_tgt = ch;
        if (state == ST_IDLE && nxt == ST_SEEK) begin
            dr_we  = 1'b1;
            dr_tgt = '0;
        end else if (state == ST_IDLE && nxt == ST_RUN) begin
            dr_we  = 1'b1;
            dr_tgt = cmd_ch;
            dr_val = cmd_dir;
        end else if (state == ST_SEEK && nxt == ST_BACK) begin
            dr_we  = 1'b1;
            dr_val = ~HOME_DIR;
        end else if (state == ST_BACK && nxt == ST_SEEK) begin
            dr_we  = 1'b1;
            dr_tgt = ch + CH_W'(1);
        end
    end

    always_ff @(posedge sysclk or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            cmd       <= '0;
            ch        <= '0;
            stp_cnt   <= '0;
            stop_seen <= 1'b0;
            fault     <= FLT_NONE;
        end else begin
            state <= nxt;
            if (state == ST_SEEK && stop_rise) stop_seen <= 1'b1;
            if (gen_start) begin
                stp_cnt   <= '0;
                stop_seen <= 1'b0;
            end else if (pos_step) begin
                stp_cnt <= stp_cnt + CNT_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (INIT) begin
                        fault <= FLT_NONE;
                        ch    <= '0;
                    end else if (accept) begin
                        ch        <= cmd_ch;
                        cmd.steps <= cmd_steps;
                        cmd.half  <= DIV_W'(clamp_half(32'(cmd_half)));
                    end
                end
                ST_SEEK, ST_BACK: begin
                    if (abort)                                fault <= FLT_ABORT;
                    else if (nxt == ST_IDLE && !home_set)     fault <= FLT_HOME_TO;
                    else if (state == ST_BACK && nxt == ST_SEEK) ch <= ch + CH_W'(1);
                end
                ST_RUN: begin
                    if (abort)        fault <= FLT_ABORT;
                    else if (stop_ch) fault <= FLT_LIMIT;
                end
                default: ;
            endcase
        end
    end

    step_gen #(.DIV_W(DIV_W)) u_gen (
        .sysclk    (sysclk),
        .rst       (RST),
        .start     (gen_start),
        .kill      (gen_kill),
        .half      (half_cur),
        .pu        (pu),
        .step_done (step_done),
        .phase_end (phase_end)
    );

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic             dr_r, homed_r;
        logic [POS_W-1:0] pos_r;

        assign chsel[i] = (ch == CH_W'(i));

        always_ff @(posedge sysclk or posedge RST) begin
            if (RST) begin
                dr_r    <= 1'b0;
                homed_r <= 1'b0;
                pos_r   <= '0;
            end else begin
                if (dr_we && dr_tgt == CH_W'(i)) dr_r <= dr_val;
                if (state == ST_IDLE && INIT)   homed_r <= 1'b0;
                else if (home_set && chsel[i])  homed_r <= 1'b1;
                if (home_set && chsel[i])
                    pos_r <= '0;
                else if (pos_step && chsel[i])
                    pos_r <= (dr_r != HOME_DIR) ? pos_r + POS_W'(1) : pos_r - POS_W'(1);
            end
        end

        assign DR[i]    = dr_r;
        assign homed[i] = homed_r;
        assign pos[i]   = pos_r;
        assign PU[i]    = chsel[i] ? pu : 1'b1;
        assign MF[i]    = chsel[i] & act;
    end

    always_comb begin
        pos_rd = '0;
        for (int i = 0; i < N_CH; i++)
            if (pos_sel == CH_W'(i)) pos_rd = pos[i];
    end

endmodule

// File: tb/tb_pulse_ctrl_multi.sv
// Directed bench for pulse_ctrl_multi with N_CH=2, HOME_HALF=2, HOME_MAX=5.
// Inputs are driven and outputs sampled on the falling clock edge; "sample k"
// is the k-th falling edge after the handshake/INIT rising edge.
module tb_pulse_ctrl_multi;

    localparam int N_CH = 2, CH_W = 2, CNT_W = 10, DIV_W = 23, POS_W = 16;

    logic             sysclk = 1'b0;
    logic             RST, INIT, cmd_valid, cmd_dir, abort;
    logic             cmd_ready, Busy, done;
    logic [CH_W-1:0]  cmd_ch, pos_sel;
    logic [CNT_W-1:0] cmd_steps;
    logic [DIV_W-1:0] cmd_half;
    logic [N_CH-1:0]  Stop, homed, PU, MF, DR;
    logic [1:0]       fault;
    logic [POS_W-1:0] pos_rd;

    int checks   = 0;
    int failures = 0;

    always #5 sysclk = ~sysclk;

    pulse_ctrl_multi #(
        .N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W), .DIV_W(DIV_W), .POS_W(POS_W),
        .HOME_HALF(2), .HOME_MAX(5), .HOME_DIR(1'b0)
    ) dut (
        .sysclk(sysclk), .RST(RST), .INIT(INIT), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_steps(cmd_steps),
        .cmd_dir(cmd_dir), .cmd_half(cmd_half), .abort(abort), .Stop(Stop),
        .Busy(Busy), .homed(homed), .done(done), .fault(fault), .PU(PU),
        .MF(MF), .DR(DR), .pos_sel(pos_sel), .pos_rd(pos_rd)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic rd_pos(input logic [CH_W-1:0] c, output logic [POS_W-1:0] v);
        pos_sel = c;
        #1 v = pos_rd;
    endtask

    // Called on a falling edge; returns on sample 0.
    task automatic send(input logic [CH_W-1:0] c, input logic [CNT_W-1:0] s,
                        input logic d, input logic [DIV_W-1:0] h);
        cmd_ch = c; cmd_steps = s; cmd_dir = d; cmd_half = h; cmd_valid = 1'b1;
        @(negedge sysclk);
        cmd_valid = 1'b0;
    endtask

    task automatic pulse_init();
        INIT = 1'b1;
        @(negedge sysclk);
        INIT = 1'b0;
    endtask

    task automatic wait_rises(input int c, input int n, input string tag);
        int   seen = 0;
        int   cyc  = 0;
        logic prev = PU[c];
        while (seen < n && cyc < 400) begin
            @(negedge sysclk);
            cyc++;
            if (PU[c] && !prev) seen++;
            prev = PU[c];
        end
        chk(tag, 32'(seen < n), 0);
    endtask

    task automatic wait_dr(input int c, input logic v, input string tag);
        int cyc = 0;
        while (DR[c] !== v && cyc < 400) begin
            @(negedge sysclk);
            cyc++;
        end
        chk(tag, DR[c], v);
    endtask

    task automatic wait_homed(input int c, input string tag);
        int cyc = 0;
        while (homed[c] !== 1'b1 && cyc < 400) begin
            @(negedge sysclk);
            cyc++;
        end
        chk(tag, homed[c], 1);
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        while (Busy !== 1'b0 && cyc < 400) begin
            @(negedge sysclk);
            cyc++;
        end
        chk(tag, Busy, 0);
    endtask

    // Stop[c] raised after 3 seek steps, dropped after 2 back-steps.
    task automatic home_all();
        logic [POS_W-1:0] p;
        pulse_init();
        chk("init_homed_clr", homed, 0);
        chk("init_fault_clr", fault, 0);
        for (int c = 0; c < N_CH; c++) begin
            wait_rises(c, 3, "seek_rises");
            chk("seek_dr", DR[c], 0);
            chk("seek_mf", MF, 32'(1 << c));
            Stop[c] = 1'b1;
            wait_dr(c, 1'b1, "back_dr");
            wait_rises(c, 2, "back_rises");
            Stop[c] = 1'b0;
            wait_homed(c, "homed_ch");
        end
        wait_idle("home_idle");
        chk("home_homed", homed, 2'b11);
        chk("home_ready", cmd_ready, 1);
        chk("home_fault", fault, 0);
        rd_pos(0, p); chk("home_pos0", p, 0);
        rd_pos(1, p); chk("home_pos1", p, 0);
    endtask

    logic [23:0]      pu_v, done_v, mf_v;
    logic [POS_W-1:0] p;
    logic             pu_other;

    initial begin
        RST = 1'b1; INIT = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; abort = 1'b0;
        cmd_ch = '0; cmd_steps = '0; cmd_half = '0; Stop = '0; pos_sel = '0;
        repeat (2) @(negedge sysclk);
        chk("rst_pu", PU, 2'b11);
        chk("rst_mf", MF, 0);
        chk("rst_dr", DR, 0);
        chk("rst_homed", homed, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_ready", cmd_ready, 0);
        rd_pos(0, p); chk("rst_pos", p, 0);
        RST = 1'b0;
        @(negedge sysclk);

        home_all();

        // ch1, 4 steps, dir 1, half 3: 1 idle cycle then 4 x (3 low, 3 high)
        send(1, 4, 1'b1, 3);
        pu_other = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (k > 0) @(negedge sysclk);
            pu_v[k] = PU[1]; done_v[k] = done; mf_v[k] = MF[1];
            pu_other &= PU[0];
        end
        chk("run_pu_wave", pu_v, 24'hC71C71);
        chk("run_done", done_v, 24'h800000);
        chk("run_mf", mf_v, 24'h7FFFFF);
        chk("run_pu0_idle", pu_other, 1);
        @(negedge sysclk);
        rd_pos(1, p); chk("run_pos1", p, 4);
        chk("run_ready", cmd_ready, 1);

        // zero steps: done on sample 0, no PU activity
        send(0, 0, 1'b1, 5);
        pu_other = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge sysclk);
            done_v[k] = done;
            pu_other &= &PU;
        end
        chk("zero_done", done_v[3:0], 4'b0001);
        chk("zero_pu", pu_other, 1);

        // out-of-range channel: same, nothing moves
        send(3, 5, 1'b0, 2);
        pu_other = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge sysclk);
            done_v[k] = done;
            pu_other &= &PU & ~|MF;
        end
        chk("badch_done", done_v[3:0], 4'b0001);
        chk("badch_quiet", pu_other, 1);

        // half=0 acts as 1: 1-low/1-high pulses
        send(0, 2, 1'b1, 0);
        for (int k = 0; k < 7; k++) begin
            if (k > 0) @(negedge sysclk);
            pu_v[k] = PU[0]; done_v[k] = done;
        end
        chk("half0_pu", pu_v[6:0], 7'h75);
        chk("half0_done", done_v[6:0], 7'h20);
        rd_pos(0, p); chk("half0_pos0", p, 2);

        // abort in the 2nd low phase (samples 7..9) of a 5-step move
        send(0, 5, 1'b1, 3);
        for (int k = 1; k < 8; k++) @(negedge sysclk);
        chk("abort_pre_pu", PU[0], 0);
        abort = 1'b1;
        @(negedge sysclk);
        abort = 1'b0;
        chk("abort_pu", PU[0], 1);
        chk("abort_done", done, 1);
        chk("abort_fault", fault, 2'b11);
        @(negedge sysclk);
        chk("abort_done_end", done, 0);
        chk("abort_ready", cmd_ready, 0);
        rd_pos(0, p); chk("abort_pos0", p, 3);

        home_all();

        // Stop[0] raised at sample 5 of a RUN: fault 10 three cycles later
        send(0, 10, 1'b0, 3);
        for (int k = 1; k < 6; k++) @(negedge sysclk);
        Stop[0] = 1'b1;
        @(negedge sysclk);
        @(negedge sysclk);
        chk("lim_fault_early", fault, 0);
        @(negedge sysclk);
        chk("lim_fault", fault, 2'b10);
        chk("lim_pu", PU[0], 1);
        chk("lim_done", done, 1);
        Stop[0] = 1'b0;
        @(negedge sysclk);
        chk("lim_ready", cmd_ready, 0);

        // homing with no limit switch: timeout after HOME_MAX=5 steps
        pulse_init();
        for (int k = 1; k < 20; k++) @(negedge sysclk);
        chk("to_busy_pre", Busy, 1);
        chk("to_fault_pre", fault, 0);
        @(negedge sysclk);
        chk("to_fault", fault, 2'b01);
        chk("to_busy", Busy, 0);
        chk("to_homed0", homed[0], 0);
        chk("to_pu", PU, 2'b11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
